// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// One operand bit per cycle; results land in HI/LO WIDTH+1 edges after start, with a done pulse.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       functcode,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   a_raw;
  logic               neg_lo, neg_hi, div_zero, op_div;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               accept, is_mul, is_div, is_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept    = start && (state == IDLE);
  assign is_mul    = (functcode == F_MULT) || (functcode == F_MULTU);
  assign is_div    = (functcode == F_DIV)  || (functcode == F_DIVU);
  assign is_signed = (functcode == F_MULT) || (functcode == F_DIV);
  assign a_abs     = (is_signed && rs_content[WIDTH-1]) ? -rs_content : rs_content;
  assign b_abs     = (is_signed && rt_content[WIDTH-1]) ? -rt_content : rt_content;

  // Shift-add: the multiplier sits in the low half of acc and drains out as the product fills in.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};

  // Restoring divide: the top bit of the trial subtract says whether the divisor fit.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd};

  assign prod_fix  = neg_lo ? -acc : acc;
  assign quo_fix   = neg_lo ? -quo : quo;
  assign rem_fix   = neg_hi ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_nxt = MUL;
        else if (accept && is_div) state_nxt = DIV;
      end
      MUL, DIV: if (count == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = done_q;
    HI   = hi_q;
    LO   = lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      a_raw    <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      op_div   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: begin
          if (accept && (is_mul || is_div)) begin
            count    <= '0;
            a_raw    <= rs_content;
            op_div   <= is_div;
            div_zero <= (rt_content == '0);
            neg_lo   <= is_signed && (rs_content[WIDTH-1] ^ rt_content[WIDTH-1]);
            neg_hi   <= is_signed && rs_content[WIDTH-1];
            if (is_mul) begin
              opnd <= a_abs;
              acc  <= {{WIDTH{1'b0}}, b_abs};
            end else begin
              opnd <= b_abs;
              quo  <= a_abs;
              rem  <= '0;
            end
          end else if (accept && (functcode == F_MTHI)) begin
            hi_q <= rs_content;
          end else if (accept && (functcode == F_MTLO)) begin
            lo_q <= rs_content;
          end
        end
        MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        DIV: begin
          if (!div_trial[WIDTH]) begin
            rem <= div_trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
        end
        FIX: begin
          if (!op_div) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            // Divide by zero returns all-ones quotient and the raw dividend, regardless of signs.
            hi_q <= a_raw;
            lo_q <= {WIDTH{1'b1}};
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench: stimulus pushes expected HI/LO and completion cycle; a monitor pops on done.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    functcode = 6'h0;
  logic [W-1:0]  rs_content = '0;
  logic [W-1:0]  rt_content = '0;
  logic          busy, done;
  logic [W-1:0]  HI, LO;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           done_seen = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .functcode(functcode),
    .rs_content(rs_content), .rt_content(rt_content),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference results straight from the arithmetic definition: {HI, LO}.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint x, y, q, r;
    logic [63:0] p;
    p = '0;
    case (f)
      6'h18: begin x = $signed(a); y = $signed(b); p = x * y; end
      6'h19: p = {32'b0, a} * {32'b0, b};
      6'h1a, 6'h1b: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          if (f == 6'h1a) begin x = $signed(a); y = $signed(b); end
          else            begin x = {32'b0, a};  y = {32'b0, b};  end
          q = x / y;
          r = x % y;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic bit is_muldiv(input logic [5:0] f);
    return (f == 6'h18) || (f == 6'h19) || (f == 6'h1a) || (f == 6'h1b);
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result_hi", {32'b0, HI}, {32'b0, e.hi});
        chk("result_lo", {32'b0, LO}, {32'b0, e.lo});
        chk("done_latency", 64'(cyc), 64'(e.due));
        cur_hi = e.hi;
        cur_lo = e.lo;
      end
    end
  end

  task automatic push_exp(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] r;
    r = ref_op(f, a, b);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.due = cyc + W + 2;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("wait_idle_timeout", 64'd1, 64'd0);
    functcode = f; rs_content = a; rt_content = b; start = 1'b1;
    if (is_muldiv(f)) push_exp(f, a, b);
    @(negedge clk);
    start = 1'b0;
    rs_content = $urandom;
    rt_content = $urandom;
    if (is_muldiv(f)) begin
      chk("busy_after_start", {63'b0, busy}, 64'd1);
    end else begin
      if (f == 6'h11) cur_hi = a;
      if (f == 6'h13) cur_lo = a;
      chk("idle_op_hilo", {HI, LO}, {cur_hi, cur_lo});
      chk("idle_op_no_busy_done", {62'b0, busy, done}, 64'd0);
    end
  endtask

  task automatic wait_done_cycle();
    int guard;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!done) chk("wait_done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [5:0]   fset[8];
    logic [W-1:0] corner[5];
    logic [W-1:0] a, b;
    int           seen, guard;
    fset   = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13, 6'h00, 6'h2a};
    corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    #3;
    chk("reset_state", {30'b0, busy, done, HI, LO}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset in the middle of a multiply wipes HI/LO and drops the result.
    issue(6'h11, 32'h1111_1111, 32'h0);
    issue(6'h13, 32'h2222_2222, 32'h0);
    issue(6'h18, 32'hFFFF_FFFE, 32'h3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop_reset", {31'b0, busy, HI, LO}, 64'd0);
    exp_q.delete();
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = done_seen;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", 64'(done_seen), 64'(seen));

    // Directed arithmetic cases.
    issue(6'h18, 32'hFFFF_FFFE, 32'h0000_0003);
    issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(6'h1a, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(6'h1b, 32'd100, 32'd7);
    issue(6'h1b, 32'h0000_1234, 32'h0);
    issue(6'h1a, 32'hFFFF_FFF9, 32'h0);
    issue(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);

    // MTLO while busy must be ignored; in IDLE it lands on the next edge.
    issue(6'h19, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    functcode = 6'h13; rs_content = 32'hAAAA_5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_while_busy_lo", {32'b0, LO}, {32'b0, cur_lo});
    chk("mtlo_while_busy_busy", {63'b0, busy}, 64'd1);
    issue(6'h13, 32'hAAAA_5555, 32'h0);
    chk("mtlo_idle_lo", {32'b0, LO}, 64'hAAAA_5555);

    // Back-to-back: new start in the done cycle of a DIVU.
    issue(6'h1b, 32'd100, 32'd7);
    wait_done_cycle();
    functcode = 6'h19; rs_content = 32'd3; rt_content = 32'd5; start = 1'b1;
    push_exp(6'h19, 32'd3, 32'd5);
    @(negedge clk);
    start = 1'b0;
    rs_content = $urandom;
    chk("b2b_accepted_busy", {63'b0, busy}, 64'd1);

    // Randomized mix including unsupported function codes.
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      issue(fset[$urandom_range(0, 7)], a, b);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
